// File: rtl/cpu_trace_emitter.sv
// Serialises one CPU write-trace record into an ASCII frame, one character per
// char_valid/char_ready handshake.
module cpu_trace_emitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        frame_done
);

    typedef enum logic [3:0] {
        StIdle, StCaret, StTime, StAt, StPc, StColon, StSpace, StTag,
        StRegnum, StAddr, StArrow, StData, StHash
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        alive_q;
    logic        kind_q;
    logic [13:0] time_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [4:0]  reg_q;

    logic        accept, advance;
    logic [13:0] tsat;
    logic [3:0]  t_th, t_hu, t_te, t_on, t_dig;
    logic [3:0]  r_te, r_on;
    logic [2:0]  t_start;

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Nibble i of w, counted from the most significant end.
    function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [2:0] i);
        logic [3:0] n;
        n = 4'(w >> (5'd28 - {i, 2'b00}));
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // alive_q holds in_ready low until the first edge after reset release.
    assign in_ready = alive_q && (state_q == StIdle);
    assign accept   = in_valid && in_ready;
    assign advance  = char_valid && char_ready;

    assign tsat    = (time_q > 14'd9999) ? 14'd9999 : time_q;
    assign t_th    = 4'(tsat / 14'd1000);
    assign t_hu    = 4'((tsat / 14'd100) % 14'd10);
    assign t_te    = 4'((tsat / 14'd10) % 14'd10);
    assign t_on    = 4'(tsat % 14'd10);
    assign t_start = (tsat >= 14'd1000) ? 3'd0 :
                     (tsat >= 14'd100)  ? 3'd1 :
                     (tsat >= 14'd10)   ? 3'd2 : 3'd3;
    assign r_te    = 4'(reg_q / 5'd10);
    assign r_on    = 4'(reg_q % 5'd10);

    always_comb begin
        unique case (idx_q[1:0])
            2'd0:    t_dig = t_th;
            2'd1:    t_dig = t_hu;
            2'd2:    t_dig = t_te;
            default: t_dig = t_on;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        char       = 8'h00;
        char_valid = 1'b1;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                char_valid = 1'b0;
                if (accept) state_d = StCaret;
            end
            StCaret: begin
                char = "^";
                if (advance) begin
                    state_d = StTime;
                    idx_d   = t_start;
                end
            end
            StTime: begin
                char = dec_char(t_dig);
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd3) begin
                        state_d = StAt;
                        idx_d   = 3'd0;
                    end
                end
            end
            StAt: begin
                char = "@";
                if (advance) state_d = StPc;
            end
            StPc: begin
                char = hex_char(pc_q, idx_q);
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StColon;
                end
            end
            StColon: begin
                char = ":";
                if (advance) state_d = StSpace;
            end
            StSpace: begin
                char = " ";
                if (advance) state_d = StTag;
            end
            StTag: begin
                char = kind_q ? "*" : "$";
                if (advance) begin
                    state_d = kind_q ? StAddr : StRegnum;
                    idx_d   = (!kind_q && reg_q < 5'd10) ? 3'd1 : 3'd0;
                end
            end
            StRegnum: begin
                char = dec_char((idx_q == 3'd0) ? r_te : r_on);
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd1) begin
                        state_d = StArrow;
                        idx_d   = 3'd0;
                    end
                end
            end
            StAddr: begin
                char = hex_char(addr_q, idx_q);
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StArrow;
                end
            end
            StArrow: begin
                unique case (idx_q[1:0])
                    2'd1:    char = "<";
                    2'd2:    char = "=";
                    default: char = " ";
                endcase
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd3) begin
                        state_d = StData;
                        idx_d   = 3'd0;
                    end
                end
            end
            StData: begin
                char = hex_char(data_q, idx_q);
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StHash;
                end
            end
            StHash: begin
                char       = "#";
                frame_done = char_ready;
                if (advance) state_d = StIdle;
            end
            default: begin
                char_valid = 1'b0;
                state_d    = StIdle;
                idx_d      = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            alive_q <= 1'b0;
            kind_q  <= 1'b0;
            time_q  <= 14'd0;
            pc_q    <= 32'd0;
            reg_q   <= 5'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            alive_q <= 1'b1;
            if (accept) begin
                kind_q <= in_kind;
                time_q <= in_time;
                pc_q   <= in_pc;
                reg_q  <= in_reg;
                addr_q <= in_addr;
                data_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: fixed records with hand-written frames,
// backpressure, mid-frame reset and back-to-back acceptance.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_reg;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  char;
    logic        char_valid;
    logic        char_ready;
    logic        frame_done;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    cpu_trace_emitter dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_reg     (in_reg),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        ncmp++;
        assert (obs == exp) else begin
            nerr++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic k, input logic [13:0] t, input logic [31:0] pc,
                         input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        in_kind = k;
        in_time = t;
        in_pc   = pc;
        in_reg  = r;
        in_addr = a;
        in_data = d;
    endtask

    // Collects one frame; flags report handshake rule violations seen along the way.
    task automatic collect(input bit rnd, output string s, output int first_cyc,
                           output int hash_cyc, output bit ok_stable,
                           output bit ok_inready, output bit ok_done);
        logic [7:0] prev;
        bit held, got;
        s = ""; first_cyc = -1; hash_cyc = -1;
        ok_stable = 1'b1; ok_inready = 1'b1; ok_done = 1'b1;
        held = 1'b0; got = 1'b0; prev = 8'h00;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            char_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (char_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (held && char !== prev) ok_stable = 1'b0;
                if (in_ready !== 1'b0) ok_inready = 1'b0;
                if (frame_done !== (char_ready && char == "#")) ok_done = 1'b0;
                if (char_ready) begin
                    s = $sformatf("%s%c", s, char);
                    held = 1'b0;
                    if (char == "#") begin
                        got = 1'b1;
                        hash_cyc = cyc;
                    end
                end else begin
                    held = 1'b1;
                    prev = char;
                end
            end else if (frame_done !== 1'b0) begin
                ok_done = 1'b0;
            end
        end
        if (!got) ok_done = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic k, input logic [13:0] t,
                             input logic [31:0] pc, input logic [4:0] r,
                             input logic [31:0] a, input logic [31:0] d,
                             input string exp, input bit rnd);
        string s;
        int fc, hc;
        bit ok_s, ok_i, ok_d;
        @(negedge clk);
        drive(k, t, pc, r, a, d);
        in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs so a frame that re-reads them would be caught.
        drive(~k, 14'($urandom), $urandom, 5'($urandom), $urandom, $urandom);
        check({tag, ".first"}, {char_valid, char}, {1'b1, 8'h5e});
        collect(rnd, s, fc, hc, ok_s, ok_i, ok_d);
        check_str({tag, ".str"}, s, exp);
        check({tag, ".len"}, s.len(), exp.len());
        check({tag, ".done"}, ok_d, 1'b1);
        check({tag, ".in_ready_low"}, ok_i, 1'b1);
        if (rnd) check({tag, ".stable"}, ok_s, 1'b1);
    endtask

    initial begin
        string s1, s2;
        int f1, h1, f2, h2;
        bit ok_s, ok_i, ok_d;

        reset = 1'b0;
        in_valid = 1'b0;
        char_ready = 1'b1;
        drive(1'b0, 14'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        #2;
        check("rst.char_valid", char_valid, 1'b0);
        check("rst.char", char, 8'h00);
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.frame_done", frame_done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel.in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel.in_ready_after_edge", in_ready, 1'b1);

        run_frame("reg28", 1'b0, 14'd1, 32'h000031fc, 5'd28, 32'h0, 32'h89abcdef,
                  "^1@000031fc: $28 <= 89abcdef#", 1'b0);
        run_frame("mem", 1'b1, 14'd2, 32'h000031fc, 5'd7, 32'h00000010, 32'h0,
                  "^2@000031fc: *00000010 <= 00000000#", 1'b0);
        run_frame("sat", 1'b0, 14'd12000, 32'h0000abcd, 5'd0, 32'h0, 32'hdeadbeef,
                  "^9999@0000abcd: $0 <= deadbeef#", 1'b0);
        run_frame("t0", 1'b0, 14'd0, 32'hfedcba98, 5'd9, 32'h0, 32'h00000001,
                  "^0@fedcba98: $9 <= 00000001#", 1'b0);
        run_frame("t9999", 1'b1, 14'd9999, 32'h80000000, 5'd0, 32'hffffffff, 32'h12345678,
                  "^9999@80000000: *ffffffff <= 12345678#", 1'b0);
        run_frame("t10", 1'b0, 14'd10, 32'h00000004, 5'd10, 32'h0, 32'h0000000a,
                  "^10@00000004: $10 <= 0000000a#", 1'b0);
        run_frame("bp", 1'b0, 14'd345, 32'h0000beef, 5'd31, 32'h0, 32'hcafef00d,
                  "^345@0000beef: $31 <= cafef00d#", 1'b1);

        // Abort a frame while DATA is being emitted.
        @(negedge clk);
        drive(1'b0, 14'd1, 32'h000031fc, 5'd28, 32'h0, 32'h89abcdef);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        char_ready = 1'b1;
        repeat (22) @(posedge clk);
        #1;
        check("abort.in_data", char, 8'h61);
        #1;
        reset = 1'b0;
        #1;
        check("abort.char_valid", char_valid, 1'b0);
        check("abort.char", char, 8'h00);
        check("abort.in_ready", in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.in_ready_before_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("abort.in_ready_after_edge", in_ready, 1'b1);
        check("abort.no_resume", char_valid, 1'b0);
        run_frame("after_abort", 1'b1, 14'd77, 32'h00001000, 5'd3, 32'h0badf00d, 32'h55aa55aa,
                  "^77@00001000: *0badf00d <= 55aa55aa#", 1'b0);

        // Two queued records with in_valid held high.
        @(negedge clk);
        drive(1'b0, 14'd5, 32'h00000100, 5'd1, 32'h0, 32'h00000011);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 14'd6, 32'h00000104, 5'd2, 32'h00000020, 32'h00000022);
        collect(1'b0, s1, f1, h1, ok_s, ok_i, ok_d);
        check_str("b2b.first", s1, "^5@00000100: $1 <= 00000011#");
        collect(1'b0, s2, f2, h2, ok_s, ok_i, ok_d);
        in_valid = 1'b0;
        check_str("b2b.second", s2, "^6@00000104: *00000020 <= 00000022#");
        check("b2b.gap", f2 - h1, 2);
        check("b2b.done", ok_d, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
